// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly, 3-stage pipeline with valid/ready flow control.
//   A_f = A + B*W, B_f = A - B*W, optional divide-by-2, saturating outputs.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake (in_ready is combinational)
//   A_t, B_t, W            complex inputs {re, im}, DW bits per component
//   scale                  1 = halve both results (travels with the transaction)
//   out_valid / out_ready  output handshake
//   A_f, B_f               complex results {re, im}
//   ovf / ovf_clr          sticky saturation flag and its synchronous clear
module butterfly_pipe #(
    parameter int DW  = 24,
    parameter int TWF = DW - 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] A_t,
    input  logic [2*DW-1:0] B_t,
    input  logic [2*DW-1:0] W,
    input  logic            scale,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] A_f,
    output logic [2*DW-1:0] B_f,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam int unsigned PW  = 2 * DW;      // single product width
    localparam int unsigned CPW = 2 * DW + 1;  // combined product width
    localparam int unsigned SW  = DW + 2;      // sum width

    localparam logic signed [CPW-1:0] RND = CPW'(1) << (TWF - 1);

    // Whole pipeline advances together; a stalled output freezes every stage.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: registered inputs
    logic                 v1;
    logic signed [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi, s1_wr, s1_wi;
    logic                 s1_scale;

    // Stage 2: full-precision partial products
    logic                 v2;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    logic signed [DW-1:0] s2_ar, s2_ai;
    logic                 s2_scale;

    // Half-up rounding of a combined product, then optional halving of the sum.
    function automatic logic signed [SW-1:0] round_p(input logic signed [CPW-1:0] p);
        return SW'((p + RND) >>> TWF);
    endfunction

    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x,
                                                   input logic sc);
        logic signed [SW-1:0] t;
        t = x + SW'(1);
        return sc ? (t >>> 1) : x;
    endfunction

    function automatic logic out_of_range(input logic signed [SW-1:0] x);
        return x[SW-1:DW-1] != {(SW-DW+1){x[SW-1]}};
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] x);
        if (out_of_range(x))
            return x[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return x[DW-1:0];
    endfunction

    // Stage 3 combinational datapath
    logic signed [CPW-1:0] pr_full, pi_full;
    logic signed [SW-1:0]  pr, pi;
    logic signed [SW-1:0]  sa_r, sa_i, sb_r, sb_i;
    logic [DW-1:0]         af_r, af_i, bf_r, bf_i;
    logic                  any_sat;

    always_comb begin
        pr_full = CPW'(p_rr) - CPW'(p_ii);
        pi_full = CPW'(p_ir) + CPW'(p_ri);
        pr      = round_p(pr_full);
        pi      = round_p(pi_full);
        sa_r    = halve(SW'(s2_ar) + pr, s2_scale);
        sa_i    = halve(SW'(s2_ai) + pi, s2_scale);
        sb_r    = halve(SW'(s2_ar) - pr, s2_scale);
        sb_i    = halve(SW'(s2_ai) - pi, s2_scale);
        af_r    = sat(sa_r);
        af_i    = sat(sa_i);
        bf_r    = sat(sb_r);
        bf_i    = sat(sb_i);
        any_sat = out_of_range(sa_r) || out_of_range(sa_i) ||
                  out_of_range(sb_r) || out_of_range(sb_i);
    end

    // Pipeline registers; data only loads behind a valid bit so bubbles leave no trace.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            s1_ar     <= '0;
            s1_ai     <= '0;
            s1_br     <= '0;
            s1_bi     <= '0;
            s1_wr     <= '0;
            s1_wi     <= '0;
            s1_scale  <= 1'b0;
            v2        <= 1'b0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ir      <= '0;
            p_ri      <= '0;
            s2_ar     <= '0;
            s2_ai     <= '0;
            s2_scale  <= 1'b0;
            out_valid <= 1'b0;
            A_f       <= '0;
            B_f       <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_ar    <= A_t[2*DW-1:DW];
                s1_ai    <= A_t[DW-1:0];
                s1_br    <= B_t[2*DW-1:DW];
                s1_bi    <= B_t[DW-1:0];
                s1_wr    <= W[2*DW-1:DW];
                s1_wi    <= W[DW-1:0];
                s1_scale <= scale;
            end
            v2 <= v1;
            if (v1) begin
                p_rr     <= s1_br * s1_wr;
                p_ii     <= s1_bi * s1_wi;
                p_ir     <= s1_bi * s1_wr;
                p_ri     <= s1_br * s1_wi;
                s2_ar    <= s1_ar;
                s2_ai    <= s1_ai;
                s2_scale <= s1_scale;
            end
            out_valid <= v2;
            if (v2) begin
                A_f <= {af_r, af_i};
                B_f <= {bf_r, bf_i};
            end
        end
    end

    // Sticky saturation flag; a coincident set wins over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (en && v2 && any_sat)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
module tb_butterfly_pipe;

    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] A_t, B_t, W;
    logic            scale;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] A_f, B_f;
    logic            ovf;
    logic            ovf_clr;

    butterfly_pipe #(.DW(DW), .TWF(DW-1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_t(A_t), .B_t(B_t), .W(W), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_f(A_f), .B_f(B_f), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ar, ai, br, bi, wr, wi;
        bit sc;
        int afr, afi, bfr, bfi;
        bit ov;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int re(input logic [2*DW-1:0] x);
        return int'($signed(x[2*DW-1:DW]));
    endfunction

    function automatic int im(input logic [2*DW-1:0] x);
        return int'($signed(x[DW-1:0]));
    endfunction

    task automatic drive(input vec_t v);
        A_t   = {DW'(v.ar), DW'(v.ai)};
        B_t   = {DW'(v.br), DW'(v.bi)};
        W     = {DW'(v.wr), DW'(v.wi)};
        scale = v.sc;
    endtask

    // Waits (bounded) for out_valid; returns cycles elapsed since acceptance edge.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One isolated transaction: latency, both results, and ovf; then clears ovf.
    task automatic run_vec(input vec_t v, input string tag, input bit clr);
        int n;
        drive(v);
        in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_af_re"}, re(A_f), v.afr);
        chk({tag, "_af_im"}, im(A_f), v.afi);
        chk({tag, "_bf_re"}, re(B_f), v.bfr);
        chk({tag, "_bf_im"}, im(B_f), v.bfi);
        chk({tag, "_ovf"}, int'(ovf), int'(v.ov));
        @(negedge clk);
        if (clr) begin
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            chk({tag, "_ovf_clr"}, int'(ovf), 0);
        end
    endtask

    localparam int H   = 4194304;   // 0.5 in Q23
    localparam int MX  = 8388607;
    localparam int MN  = -8388608;

    vec_t vecs[9];
    vec_t bp[5];

    initial begin
        int n, cnt, idx, rcv;
        bit saw_stall, held;
        logic [2*DW-1:0] prev_af, prev_bf;

        //          ar   ai   br    bi   wr  wi  sc  afr  afi  bfr   bfi  ov
        vecs[0] = '{100, 0,   200,  0,   H,  0,  0,  200, 0,   0,    0,   0};
        vecs[1] = '{100, 0,   200,  0,   H,  0,  1,  100, 0,   0,    0,   0};
        vecs[2] = '{0,   0,   1000, -500, 0, H,  0,  250, 500, -250, -500, 0};
        vecs[3] = '{MX,  0,   MX,   0,   MX, 0,  0,  MX,  0,   1,    0,   1};
        vecs[4] = '{MN,  0,   MX,   0,   MN, 0,  0,  MN,  0,   -1,   0,   1};
        vecs[5] = '{0,   0,   3,    0,   H,  0,  0,  2,   0,   -2,   0,   0};
        vecs[6] = '{0,   0,   -3,   0,   H,  0,  0,  -1,  0,   1,    0,   0};
        vecs[7] = '{0,   0,   3,    0,   H,  0,  1,  1,   0,   -1,   0,   0};
        vecs[8] = '{MX,  0,   MX,   0,   MX, 0,  1,  MX,  0,   1,    0,   0};

        bp[0] = '{100, 3,  2,  0, H, 0, 0, 101, 3,  99,  3,  0};
        bp[1] = '{200, 6,  4,  0, H, 0, 1, 101, 3,  99,  3,  0};
        bp[2] = '{300, 9,  6,  0, H, 0, 0, 303, 9,  297, 9,  0};
        bp[3] = '{400, 12, 8,  0, H, 0, 1, 202, 6,  198, 6,  0};
        bp[4] = '{500, 15, 10, 0, H, 0, 0, 505, 15, 495, 15, 0};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        A_t = '0; B_t = '0; W = '0; scale = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_af_zero", int'(A_f == '0 && B_f == '0), 1);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Directed vectors
        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // Clear coinciding with a saturating update: set must win
        drive(vecs[3]);
        in_valid = 1'b1;
        ovf_clr  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        chk("prio_latency", n, 3);
        chk("prio_ovf_set_wins", int'(ovf), 1);
        @(negedge clk);
        chk("prio_ovf_cleared_after", int'(ovf), 0);
        ovf_clr = 1'b0;

        // Backpressure: 5 back-to-back, out_ready low for 4 cycles
        idx = 0; rcv = 0; saw_stall = 0; held = 0;
        prev_af = '0; prev_bf = '0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 5) begin
                drive(bp[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("bp_hold_valid", int'(out_valid), 1);
                chk("bp_hold_data", int'(A_f == prev_af && B_f == prev_bf), 1);
            end
            if (!in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                chk($sformatf("bp%0d_af_re", rcv), re(A_f), bp[rcv].afr);
                chk($sformatf("bp%0d_af_im", rcv), im(A_f), bp[rcv].afi);
                chk($sformatf("bp%0d_bf_re", rcv), re(B_f), bp[rcv].bfr);
                chk($sformatf("bp%0d_bf_im", rcv), im(B_f), bp[rcv].bfi);
                rcv++;
            end
            if (in_valid && in_ready) idx++;
            held    = out_valid && !out_ready;
            prev_af = A_f;
            prev_bf = B_f;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_received", rcv, 5);
        chk("bp_in_ready_dropped", int'(saw_stall), 1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        chk("bp_no_duplicates", cnt, 0);

        // Reset mid-stream with ovf set and two transactions in flight
        run_vec(vecs[3], "pre_rst", 1'b0);
        chk("pre_rst_ovf_sticky", int'(ovf), 1);
        drive(vecs[3]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[4]);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        // Idle with saturating-looking data on the bus but in_valid low
        drive(vecs[3]);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("postrst_no_stale", cnt, 0);
        chk("idle_ovf_untouched", int'(ovf), 0);
        run_vec(vecs[0], "postrst", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
